// File: rtl/game_pkg.sv
// game_pkg -- shared encodings and defaults for the whack-a-mole game sequencer.
//   phase_t   : IDLE / COUNTDOWN / PLAYING / DONE phase encoding (phase_o)
//   mode_t    : difficulty encoding (mode_i / mode_o)
//   *_DEFAULT : default countdown and game lengths in seconds
//   CD_W / TIMER_W : widths of the countdown and game-timer counters
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    PLAYING   = 2'b10,
    DONE      = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_SLOW   = 2'b01,
    MODE_MEDIUM = 2'b10,
    MODE_FAST   = 2'b11
  } mode_t;

  localparam int COUNTDOWN_S_DEFAULT = 3;
  localparam int GAME_S_DEFAULT      = 30;

  // Countdown spans 1..9 seconds, game timer 1..255 seconds.
  localparam int CD_W    = 4;
  localparam int TIMER_W = 8;

endpackage

// File: rtl/sec_down_counter.sv
// sec_down_counter -- loadable seconds down-counter that stops at zero.
//   clk   in  : clock
//   rst   in  : asynchronous active-high reset (count -> 0)
//   load  in  : load value into count (takes priority over tick)
//   value in  : W-bit load value
//   tick  in  : decrement strobe; ignored once count reaches 0
//   count out : registered current count
//   zero  out : high while count is 0
module sec_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer -- phase sequencer for a whack-a-mole game:
// IDLE -> COUNTDOWN -> PLAYING -> DONE, with score counting and display mux.
//   clock_i       in  : system clock (only clock)
//   reset_i       in  : asynchronous active-high reset
//   tick_1hz_i    in  : one-cycle strobe once per second
//   start_i       in  : one-cycle start request
//   mode_i        in  : difficulty (00 none, 01 slow, 10 medium, 11 fast)
//   whack_i       in  : one-cycle successful-hit strobe
//   phase_o       out : current phase
//   mode_o        out : mode latched at game start
//   mole_en_o     out : high only while PLAYING
//   time_left_o   out : seconds remaining in PLAYING
//   score_o       out : current score (saturating)
//   disp_value_o  out : value for the BCD/seven-segment path
//   disp_blank_o  out : display blanked (IDLE)
//   high_score_o  out : best final score since reset
// Build option: define GAME_SEQUENCER_HIGH_SCORE_EN to build the high-score
// register; otherwise high_score_o is tied to 0.
module game_sequencer
  import game_pkg::*;
#(
  parameter int COUNTDOWN_S = COUNTDOWN_S_DEFAULT,
  parameter int GAME_S      = GAME_S_DEFAULT,
  parameter int SCORE_W     = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               tick_1hz_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               whack_i,
  output logic [1:0]         phase_o,
  output logic [1:0]         mode_o,
  output logic               mole_en_o,
  output logic [7:0]         time_left_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [15:0]        disp_value_o,
  output logic               disp_blank_o,
  output logic [SCORE_W-1:0] high_score_o
);

  phase_t              phase;
  logic [CD_W-1:0]     cd_count;
  logic                cd_zero;
  logic                gm_zero;
  logic                start_ok;
  logic                cd_tick;
  logic                cd_last;
  logic                gm_tick;
  logic                gm_last;
  logic [SCORE_W-1:0]  score_next;

  assign phase_o = phase;

  // A start is honoured only from IDLE or DONE, and only with a real mode.
  // Because start wins in IDLE, a coincident tick is simply not consumed.
  assign start_ok = start_i && (mode_i != MODE_NONE) &&
                    ((phase == IDLE) || (phase == DONE));
  assign cd_tick  = tick_1hz_i && (phase == COUNTDOWN) && !cd_zero;
  assign cd_last  = cd_tick && (cd_count == CD_W'(1));
  assign gm_tick  = tick_1hz_i && (phase == PLAYING) && !gm_zero;
  assign gm_last  = gm_tick && (time_left_o == 8'd1);

  // Saturating score increment; a whack on the final tick still counts.
  always_comb begin
    score_next = score_o;
    if ((phase == PLAYING) && whack_i && (score_o != {SCORE_W{1'b1}})) begin
      score_next = score_o + SCORE_W'(1);
    end
  end

  sec_down_counter #(.W(CD_W)) u_countdown (
    .clk   (clock_i),
    .rst   (reset_i),
    .load  (start_ok),
    .value (CD_W'(COUNTDOWN_S)),
    .tick  (cd_tick),
    .count (cd_count),
    .zero  (cd_zero)
  );

  // The last countdown tick loads the game timer on the same edge PLAYING starts.
  sec_down_counter #(.W(TIMER_W)) u_game_timer (
    .clk   (clock_i),
    .rst   (reset_i),
    .load  (cd_last),
    .value (TIMER_W'(GAME_S)),
    .tick  (gm_tick),
    .count (time_left_o),
    .zero  (gm_zero)
  );

  // Phase FSM with registered outputs; the display register is fed the value
  // each counter/score will hold after this edge so it never lags a cycle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      phase        <= IDLE;
      mode_o       <= MODE_NONE;
      mole_en_o    <= 1'b0;
      score_o      <= '0;
      disp_value_o <= '0;
      disp_blank_o <= 1'b1;
    end else if (start_ok) begin
      phase        <= COUNTDOWN;
      mode_o       <= mode_i;
      mole_en_o    <= 1'b0;
      score_o      <= '0;
      disp_value_o <= 16'(COUNTDOWN_S);
      disp_blank_o <= 1'b0;
    end else begin
      case (phase)
        COUNTDOWN: begin
          if (cd_last) begin
            phase        <= PLAYING;
            mole_en_o    <= 1'b1;
            disp_value_o <= 16'(score_o);
          end else if (cd_tick) begin
            disp_value_o <= 16'(cd_count - CD_W'(1));
          end
        end
        PLAYING: begin
          score_o      <= score_next;
          disp_value_o <= 16'(score_next);
          if (gm_last) begin
            phase     <= DONE;
            mole_en_o <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE hold everything until a valid start.
        end
      endcase
    end
  end

`ifdef GAME_SEQUENCER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score;

  // Captured on the PLAYING->DONE edge only, so a reset mid-game never records.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      high_score <= '0;
    end else if (gm_last && (score_next > high_score)) begin
      high_score <= score_next;
    end
  end

  assign high_score_o = high_score;
`else
  assign high_score_o = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer -- scoreboard bench for game_sequencer. A behavioural
// model predicts every cycle's outputs when stimulus is driven; test tasks pop
// and compare after the clock edge. A second instance with SCORE_W = 4 shares
// the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int CD = 3;
  localparam int GS = 30;
`ifdef GAME_SEQUENCER_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        whack = 1'b0;
  logic [1:0]  mode  = 2'b00;

  logic [1:0]  phase, mode_q;
  logic        mole;
  logic [7:0]  time_left;
  logic [15:0] score, disp, high;
  logic        blank;

  logic [1:0]  phase4, mode_q4;
  logic        mole4, blank4;
  logic [7:0]  time_left4;
  logic [15:0] disp4;
  logic [3:0]  score4, high4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  phase;
    logic [1:0]  mode;
    logic        mole;
    logic [7:0]  tl;
    logic [15:0] score;
    logic [15:0] disp;
    logic        blank;
    logic [15:0] high;
    logic [3:0]  score4;
    logic [3:0]  high4;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_phase, m_mode, m_cd, m_tl, m_score, m_score4, m_high, m_high4;

  always #5 clock = ~clock;

  game_sequencer dut (
    .clock_i(clock), .reset_i(reset), .tick_1hz_i(tick), .start_i(start),
    .mode_i(mode), .whack_i(whack), .phase_o(phase), .mode_o(mode_q),
    .mole_en_o(mole), .time_left_o(time_left), .score_o(score),
    .disp_value_o(disp), .disp_blank_o(blank), .high_score_o(high)
  );

  game_sequencer #(.SCORE_W(4)) dut4 (
    .clock_i(clock), .reset_i(reset), .tick_1hz_i(tick), .start_i(start),
    .mode_i(mode), .whack_i(whack), .phase_o(phase4), .mode_o(mode_q4),
    .mole_en_o(mole4), .time_left_o(time_left4), .score_o(score4),
    .disp_value_o(disp4), .disp_blank_o(blank4), .high_score_o(high4)
  );

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_cd = 0; m_tl = 0;
    m_score = 0; m_score4 = 0; m_high = 0; m_high4 = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, push the prediction.
  task automatic drive(input logic t, input logic s, input logic [1:0] md, input logic w);
    exp_t e;
    tick = t; start = s; mode = md; whack = w;
    if (s && md != 2'b00 && (m_phase == 0 || m_phase == 3)) begin
      m_mode = md; m_cd = CD; m_score = 0; m_score4 = 0; m_phase = 1;
    end else if (m_phase == 1) begin
      if (t) begin
        if (m_cd == 1) begin m_phase = 2; m_tl = GS; m_cd = 0; end
        else m_cd = m_cd - 1;
      end
    end else if (m_phase == 2) begin
      if (w) begin
        if (m_score < 65535) m_score = m_score + 1;
        if (m_score4 < 15) m_score4 = m_score4 + 1;
      end
      if (t) begin
        if (m_tl == 1) begin
          m_phase = 3; m_tl = 0;
          if (HS_EN && m_score > m_high) m_high = m_score;
          if (HS_EN && m_score4 > m_high4) m_high4 = m_score4;
        end else m_tl = m_tl - 1;
      end
    end
    e.phase  = 2'(m_phase);
    e.mode   = 2'(m_mode);
    e.mole   = (m_phase == 2);
    e.tl     = 8'(m_tl);
    e.score  = 16'(m_score);
    e.disp   = (m_phase == 0) ? 16'd0 : (m_phase == 1) ? 16'(m_cd) : 16'(m_score);
    e.blank  = (m_phase == 0);
    e.high   = 16'(m_high);
    e.score4 = 4'(m_score4);
    e.high4  = 4'(m_high4);
    sb.push_back(e);
    @(posedge clock); #1;
    tick = 1'b0; start = 1'b0; whack = 1'b0;
    $display("txn t=%0t tick=%0b start=%0b mode=%0d whack=%0b -> phase=%0d tl=%0d score=%0d disp=%0d",
             $time, t, s, md, w, phase, time_left, score, disp);
  endtask

  task automatic test_reset();
    checks++; if (phase !== 2'b00) begin failures++; $display("FAIL reset_phase act=%0d exp=0", phase); end
    checks++; if (mode_q !== 2'b00) begin failures++; $display("FAIL reset_mode act=%0d exp=0", mode_q); end
    checks++; if (mole !== 1'b0) begin failures++; $display("FAIL reset_mole act=%0b exp=0", mole); end
    checks++; if (time_left !== 8'd0) begin failures++; $display("FAIL reset_tl act=%0d exp=0", time_left); end
    checks++; if (score !== 16'd0 || score4 !== 4'd0) begin failures++; $display("FAIL reset_score act=%0d/%0d exp=0", score, score4); end
    checks++; if (disp !== 16'd0) begin failures++; $display("FAIL reset_disp act=%0d exp=0", disp); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL reset_blank act=%0b exp=1", blank); end
    checks++; if (high !== 16'd0 || high4 !== 4'd0) begin failures++; $display("FAIL reset_high act=%0d/%0d exp=0", high, high4); end
    $display("txn t=%0t reset state checked", $time);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    drive(1'b0, 1'b1, 2'b00, 1'b0);
    e = sb.pop_front();
    checks++; if (phase !== e.phase) begin failures++; $display("FAIL mode0_phase act=%0d exp=%0d", phase, e.phase); end
    checks++; if (blank !== e.blank) begin failures++; $display("FAIL mode0_blank act=%0b exp=%0b", blank, e.blank); end
    drive(1'b1, 1'b0, 2'b01, 1'b1);
    e = sb.pop_front();
    checks++; if (phase !== e.phase || score !== e.score) begin failures++; $display("FAIL idle_tick_whack act=%0d/%0d exp=%0d/%0d", phase, score, e.phase, e.score); end
  endtask

  // Start with md, then run the countdown; a start, mode change and whack
  // in the middle must all be ignored.
  task automatic test_countdown(input logic [1:0] md, input bit tick_with_start);
    exp_t e;
    drive(tick_with_start, 1'b1, md, 1'b0);
    e = sb.pop_front();
    checks++; if (phase !== e.phase) begin failures++; $display("FAIL cd_start_phase act=%0d exp=%0d", phase, e.phase); end
    checks++; if (disp !== e.disp) begin failures++; $display("FAIL cd_start_disp act=%0d exp=%0d", disp, e.disp); end
    checks++; if (mode_q !== e.mode || blank !== e.blank || score !== e.score) begin failures++; $display("FAIL cd_start_outs act=%0d/%0b/%0d exp=%0d/%0b/%0d", mode_q, blank, score, e.mode, e.blank, e.score); end
    drive(1'b0, 1'b1, ~md, 1'b1);
    e = sb.pop_front();
    checks++; if (phase !== e.phase || mode_q !== e.mode || disp !== e.disp || score !== e.score) begin failures++; $display("FAIL cd_ignore act=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", phase, mode_q, disp, score, e.phase, e.mode, e.disp, e.score); end
    for (int i = 0; i < CD; i++) begin
      drive(1'b1, 1'b0, md, 1'b0);
      e = sb.pop_front();
      checks++; if (phase !== e.phase || disp !== e.disp) begin failures++; $display("FAIL cd_tick%0d act=%0d/%0d exp=%0d/%0d", i, phase, disp, e.phase, e.disp); end
    end
    checks++; if (time_left !== e.tl) begin failures++; $display("FAIL cd_to_play_tl act=%0d exp=%0d", time_left, e.tl); end
    checks++; if (mole !== e.mole) begin failures++; $display("FAIL cd_to_play_mole act=%0b exp=%0b", mole, e.mole); end
  endtask

  // nwh whacks in separate cycles, then GS ticks; final tick may carry a whack.
  task automatic test_game(input int nwh, input bit final_whack);
    exp_t e;
    for (int i = 0; i < nwh; i++) begin
      drive(1'b0, 1'b1, 2'(i), 1'b1);
      e = sb.pop_front();
      checks++; if (score !== e.score || disp !== e.disp) begin failures++; $display("FAIL whack%0d_score act=%0d/%0d exp=%0d/%0d", i, score, disp, e.score, e.disp); end
      checks++; if (score4 !== e.score4 || mode_q !== e.mode) begin failures++; $display("FAIL whack%0d_sat_mode act=%0d/%0d exp=%0d/%0d", i, score4, mode_q, e.score4, e.mode); end
    end
    for (int i = 0; i < GS - 1; i++) begin
      drive(1'b1, 1'b0, mode, 1'b0);
      e = sb.pop_front();
      checks++; if (time_left !== e.tl || phase !== e.phase || mole !== e.mole) begin failures++; $display("FAIL play_tick%0d act=%0d/%0d/%0b exp=%0d/%0d/%0b", i, time_left, phase, mole, e.tl, e.phase, e.mole); end
    end
    drive(1'b1, 1'b0, mode, final_whack);
    e = sb.pop_front();
    checks++; if (phase !== e.phase) begin failures++; $display("FAIL done_phase act=%0d exp=%0d", phase, e.phase); end
    checks++; if (time_left !== e.tl || mole !== e.mole) begin failures++; $display("FAIL done_tl_mole act=%0d/%0b exp=%0d/%0b", time_left, mole, e.tl, e.mole); end
    checks++; if (score !== e.score || disp !== e.disp) begin failures++; $display("FAIL done_score act=%0d/%0d exp=%0d/%0d", score, disp, e.score, e.disp); end
    checks++; if (score4 !== e.score4) begin failures++; $display("FAIL done_score4 act=%0d exp=%0d", score4, e.score4); end
    checks++; if (high !== e.high || high4 !== e.high4) begin failures++; $display("FAIL done_high act=%0d/%0d exp=%0d/%0d", high, high4, e.high, e.high4); end
    // DONE holds the score; whacks and ticks are ignored.
    drive(1'b1, 1'b0, mode, 1'b1);
    e = sb.pop_front();
    checks++; if (phase !== e.phase || score !== e.score || time_left !== e.tl) begin failures++; $display("FAIL done_hold act=%0d/%0d/%0d exp=%0d/%0d/%0d", phase, score, time_left, e.phase, e.score, e.tl); end
  endtask

  // Asynchronous reset in the middle of PLAYING with score 7.
  task automatic test_reset_mid_play();
    exp_t e;
    test_countdown(2'b10, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 2'b10, 1'b1);
      e = sb.pop_front();
    end
    checks++; if (score !== e.score) begin failures++; $display("FAIL pre_reset_score act=%0d exp=%0d", score, e.score); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (phase !== 2'b00 || mode_q !== 2'b00 || mole !== 1'b0) begin failures++; $display("FAIL async_reset_ctl act=%0d/%0d/%0b exp=0/0/0", phase, mode_q, mole); end
    checks++; if (score !== 16'd0 || time_left !== 8'd0 || disp !== 16'd0) begin failures++; $display("FAIL async_reset_vals act=%0d/%0d/%0d exp=0/0/0", score, time_left, disp); end
    checks++; if (blank !== 1'b1 || high !== 16'd0) begin failures++; $display("FAIL async_reset_disp act=%0b/%0d exp=1/0", blank, high); end
    $display("txn t=%0t async reset mid-play", $time);
    @(posedge clock); #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_start_ignored();
    test_countdown(2'b01, 1'b0);
    test_game(5, 1'b1);          // score 6
    test_countdown(2'b10, 1'b0); // restart from DONE
    test_game(4, 1'b0);          // score 4, best stays 6
    test_countdown(2'b11, 1'b0);
    test_game(20, 1'b0);         // 4-bit instance saturates at 15
    test_reset_mid_play();
    test_countdown(2'b01, 1'b1); // tick coincident with start is not counted
    test_game(2, 1'b1);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover act=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
